ring_sequencer_fsm: RTL and testbench

Parametrised successor to the fixed 8-state up/down ring FSM. It sequences through NUM_STATES states (0..NUM_STATES-1) in a ring, in either direction. Added capabilities: per-state dwell counting, enable, synchronous load of a state value, wrap/step strobes, and sticky illegal-state/illegal-load error detection. It sits in FSM/controller logic that needs a programmable-length cyclic state index.

---
 rtl/ring_sequencer_fsm.sv | 104 ++++++++++
 tb/tb_ring_sequencer_fsm.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_sequencer_fsm.sv
// Programmable-length up/down ring sequencer with per-state dwell, load,
// step/wrap strobes and a sticky error flag for illegal states or loads.
module ring_sequencer_fsm #(
    parameter int NUM_STATES = 8,
    parameter int STATE_W    = $clog2(NUM_STATES),
    parameter int DWELL_W    = 4
) (
    input  logic               c,
    input  logic               rst,
    input  logic               en,
    input  logic               dir,
    input  logic               load,
    input  logic [STATE_W-1:0] load_val,
    input  logic [DWELL_W-1:0] dwell,
    output logic [STATE_W-1:0] out,
    output logic               step,
    output logic               wrap,
    output logic               err
);

    // One extra bit so the range check stays meaningful when NUM_STATES is a power of two.
    localparam logic [STATE_W:0]   NUM_S = NUM_STATES[STATE_W:0];
    localparam logic [STATE_W-1:0] LAST  = STATE_W'(NUM_STATES - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               step_q, step_d;
    logic               wrap_q, wrap_d;
    logic               err_q, err_d;

    logic state_illegal;
    logic load_legal;

    assign state_illegal = ({1'b0, state_q} >= NUM_S);
    assign load_legal    = ({1'b0, load_val} < NUM_S);

    always_comb begin
        // NOTE: every _d gets a default first so no path through the if-chain infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        err_d   = err_q;

        if (state_illegal) begin
            state_d = '0;
            cnt_d   = '0;
            err_d   = 1'b1;
        end else if (load) begin
            if (load_legal) begin
                state_d = load_val;
                cnt_d   = '0;
            end else begin
                err_d = 1'b1;
            end
        end else if (en) begin
            // >= rather than == so a dwell lowered mid-count expires at once.
            if (cnt_q >= dwell) begin
                cnt_d  = '0;
                step_d = 1'b1;
                if (dir) begin
                    if (state_q == LAST) begin
                        state_d = '0;
                        wrap_d  = 1'b1;
                    end else begin
                        state_d = state_q + 1'b1;
                    end
                end else begin
                    if (state_q == '0) begin
                        state_d = LAST;
                        wrap_d  = 1'b1;
                    end else begin
                        state_d = state_q - 1'b1;
                    end
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge c) begin
        if (rst) begin
            state_q <= '0;
            cnt_q   <= '0;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign out  = state_q;
    assign step = step_q;
    assign wrap = wrap_q;
    assign err  = err_q;

endmodule

// File: tb/tb_ring_sequencer_fsm.sv
// Directed bench for ring_sequencer_fsm: an 8-state instance for the plain
// ring and a 6-state instance for dwell, load, recovery and reset cases.
module tb_ring_sequencer_fsm;

    logic       c = 1'b0;
    logic       rst;
    logic       en;
    logic       dir;
    logic       load;
    logic [2:0] load_val;
    logic [3:0] dwell;

    logic [2:0] out8, out6;
    logic       step8, wrap8, err8;
    logic       step6, wrap6, err6;

    int vectors     = 0;
    int miscompares = 0;

    ring_sequencer_fsm #(.NUM_STATES(8), .DWELL_W(4)) dut8 (
        .c(c), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val),
        .dwell(dwell), .out(out8), .step(step8), .wrap(wrap8), .err(err8)
    );

    ring_sequencer_fsm #(.NUM_STATES(6), .DWELL_W(4)) dut6 (
        .c(c), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val),
        .dwell(dwell), .out(out6), .step(step6), .wrap(wrap6), .err(err6)
    );

    always #5 c = ~c;

    // Advance one clock and settle 1 time unit past the rising edge.
    task automatic tick();
        @(posedge c);
        #1;
    endtask

    task automatic drive(input logic r, input logic e, input logic d, input logic l,
                         input logic [2:0] lv, input logic [3:0] dw);
        rst = r; en = e; dir = d; load = l; load_val = lv; dwell = dw;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 3'd3, 4'd0);
        tick();
        vectors++;
        if ({out8, step8, wrap8, err8} !== 6'b000_000) begin
            miscompares++;
            $display("FAIL reset8: out=%0d step=%0b wrap=%0b err=%0b, want out=0 step=0 wrap=0 err=0",
                     out8, step8, wrap8, err8);
        end
        vectors++;
        if ({out6, step6, wrap6, err6} !== 6'b000_000) begin
            miscompares++;
            $display("FAIL reset6: out=%0d step=%0b wrap=%0b err=%0b, want out=0 step=0 wrap=0 err=0",
                     out6, step6, wrap6, err6);
        end
    endtask

    task automatic test_ring8_up();
        logic [2:0] exp_out;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 4'd0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp_out = 3'(k % 8);
            vectors++;
            if ({out8, step8, wrap8} !== {exp_out, 1'b1, exp_out == 3'd0}) begin
                miscompares++;
                $display("FAIL ring8_up[%0d]: out=%0d step=%0b wrap=%0b, want out=%0d step=1 wrap=%0b",
                         k, out8, step8, wrap8, exp_out, exp_out == 3'd0);
            end
        end
    endtask

    task automatic test_dwell_down();
        logic [2:0] exp_out;
        logic       exp_step;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd2);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'd2);
        for (int k = 1; k <= 9; k++) begin
            tick();
            exp_out  = 3'((6 - k / 3) % 6);
            exp_step = (k % 3 == 0);
            vectors++;
            if ({out6, step6, wrap6} !== {exp_out, exp_step, k == 3}) begin
                miscompares++;
                $display("FAIL dwell_down[%0d]: out=%0d step=%0b wrap=%0b, want out=%0d step=%0b wrap=%0b",
                         k, out6, step6, wrap6, exp_out, exp_step, k == 3);
            end
        end
    endtask

    task automatic test_load();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 4'd0);
        tick();
        vectors++;
        if ({out6, step6, wrap6, err6} !== {3'd3, 3'b000}) begin
            miscompares++;
            $display("FAIL load_legal: out=%0d step=%0b wrap=%0b err=%0b, want out=3 step=0 wrap=0 err=0",
                     out6, step6, wrap6, err6);
        end
        load_val = 3'd7;
        tick();
        vectors++;
        if ({out6, err6} !== {3'd3, 1'b1}) begin
            miscompares++;
            $display("FAIL load_illegal: out=%0d err=%0b, want out=3 err=1", out6, err6);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0);
        tick();
        vectors++;
        if ({out6, step6, err6} !== {3'd3, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL en_low_hold: out=%0d step=%0b err=%0b, want out=3 step=0 err=1", out6, step6, err6);
        end
        en = 1'b1;
        tick();
        vectors++;
        if ({out6, step6, err6} !== {3'd4, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL err_sticky: out=%0d step=%0b err=%0b, want out=4 step=1 err=1", out6, step6, err6);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0);
        tick();
        vectors++;
        if ({out6, err6} !== {3'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL err_clear: out=%0d err=%0b, want out=0 err=0", out6, err6);
        end
    endtask

    task automatic test_load_priority();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 4'd0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 4'd0);
        tick();
        vectors++;
        if ({out6, step6, wrap6, err6} !== {3'd2, 3'b000}) begin
            miscompares++;
            $display("FAIL load_priority: out=%0d step=%0b wrap=%0b err=%0b, want out=2 step=0 wrap=0 err=0",
                     out6, step6, wrap6, err6);
        end
    endtask

    task automatic test_illegal_recovery();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 4'd0);
        force dut6.state_q = 3'd7;
        #1;
        release dut6.state_q;
        vectors++;
        if (out6 !== 3'd7) begin
            miscompares++;
            $display("FAIL upset_inject: out=%0d, want out=7", out6);
        end
        tick();
        vectors++;
        if ({out6, step6, wrap6, err6} !== {3'd0, 3'b001}) begin
            miscompares++;
            $display("FAIL recovery: out=%0d step=%0b wrap=%0b err=%0b, want out=0 step=0 wrap=0 err=1",
                     out6, step6, wrap6, err6);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0);
        tick();
        vectors++;
        if ({out6, err6} !== {3'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL recovery_rst: out=%0d err=%0b, want out=0 err=0", out6, err6);
        end
    endtask

    task automatic test_rst_mid_dwell();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 3'd4, 4'd5);
        tick();
        load = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        vectors++;
        if ({out6, step6} !== {3'd4, 1'b0}) begin
            miscompares++;
            $display("FAIL mid_dwell: out=%0d step=%0b, want out=4 step=0", out6, step6);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if ({out6, step6, wrap6, err6} !== 6'b000_000) begin
            miscompares++;
            $display("FAIL rst_mid_dwell: out=%0d step=%0b wrap=%0b err=%0b, want all 0",
                     out6, step6, wrap6, err6);
        end
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            vectors++;
            if ({out6, step6} !== {3'(k == 6), k == 6}) begin
                miscompares++;
                $display("FAIL post_rst_dwell[%0d]: out=%0d step=%0b, want out=%0d step=%0b",
                         k, out6, step6, k == 6, k == 6);
            end
        end
    endtask

    task automatic test_dwell_change();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 4'd3);
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 4'd3);
        tick();
        tick();
        vectors++;
        if ({out6, step6} !== {3'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL dwell_count: out=%0d step=%0b, want out=0 step=0", out6, step6);
        end
        dir   = 1'b0;
        dwell = 4'd1;
        tick();
        vectors++;
        if ({out6, step6, wrap6} !== {3'd5, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL dwell_lowered: out=%0d step=%0b wrap=%0b, want out=5 step=1 wrap=1",
                     out6, step6, wrap6);
        end
        en = 1'b0;
        tick();
        vectors++;
        if ({out6, step6, wrap6} !== {3'd5, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL en_hold: out=%0d step=%0b wrap=%0b, want out=5 step=0 wrap=0",
                     out6, step6, wrap6);
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0);
        #1;
        test_reset();
        test_ring8_up();
        test_dwell_down();
        test_load();
        test_load_priority();
        test_illegal_recovery();
        test_rst_mid_dwell();
        test_dwell_change();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
